// File: rtl/krnl_vadd_arb_pkg.sv
// Shared types and width helpers for the vadd adder arbiter.
// Optional perf counters are enabled with KRNL_VADD_ARB_PERF_CNT_EN.
package krnl_vadd_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int tag_w(input int num_req);
        return (num_req < 2) ? 1 : clog2(num_req);
    endfunction

    // Extra MSB lets equal low bits distinguish full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/krnl_vadd_tag_fifo.sv
// In-order FIFO of requester IDs for beats in flight in the adder.
// Full is taken from the pre-pop count, so a full FIFO never accepts a push.
module krnl_vadd_tag_fifo
    import krnl_vadd_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 2
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = push & ~full;
    assign do_rd = pop & ~empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/krnl_vadd_adder_arbiter.sv
// Round-robin, burst-locked sharing of one vadd adder among NUM_REQ streams.
// Optional perf counters are enabled with KRNL_VADD_ARB_PERF_CNT_EN.
module krnl_vadd_adder_arbiter
    import krnl_vadd_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int BURST_LEN    = 8,
    parameter int TAG_DEPTH    = 16,
    localparam int TW          = tag_w(NUM_REQ),
    localparam int DW2         = 2 * C_DATA_WIDTH,
    localparam int RW          = C_DATA_WIDTH + 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUM_REQ-1:0]    req_tvalid,
    input  logic [NUM_REQ*DW2-1:0] req_tdata,
    output logic [NUM_REQ-1:0]    req_tready,
    output logic [NUM_REQ-1:0]    rsp_tvalid,
    output logic [NUM_REQ*RW-1:0] rsp_tdata,
    input  logic [NUM_REQ-1:0]    rsp_tready,
    output logic                  add_s_tvalid,
    output logic [DW2-1:0]        add_s_tdata,
    input  logic                  add_s_tready,
    input  logic                  add_m_tvalid,
    input  logic [RW-1:0]         add_m_tdata,
    output logic                  add_m_tready,
    output logic [TW-1:0]         grant_id,
    output logic                  busy,
    output logic                  tag_err
`ifdef KRNL_VADD_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_beats,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

    arb_state_e    state_q, state_d;
    logic [TW-1:0] grant_q, grant_d;
    logic [TW-1:0] rr_q, rr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] pick;
    logic [TW-1:0] scan_idx;
    logic [TW-1:0] grant_nxt;
    logic          push;
    logic          pop;
    logic          tag_full;
    logic          tag_empty;
    logic [TW-1:0] tag_head;
    logic [DW2-1:0] req_beat [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_beat[gi] = req_tdata[gi*DW2 +: DW2];
    end

    // Scan downwards so the nearest valid requester after rr_q wins.
    always_comb begin
        pick     = rr_q;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = TW'((int'(rr_q) + k) % NUM_REQ);
            if (req_tvalid[scan_idx]) pick = scan_idx;
        end
    end

    assign grant_nxt = (grant_q == TW'(NUM_REQ - 1)) ? '0 : grant_q + TW'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        req_tready   = '0;
        add_s_tvalid = 1'b0;
        push         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_tvalid) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                add_s_tvalid        = req_tvalid[grant_q] & ~tag_full;
                req_tready[grant_q] = add_s_tready & ~tag_full;
                push                = add_s_tvalid & add_s_tready;
                if (push) cnt_d = cnt_q + 8'd1;
                if (!req_tvalid[grant_q] || (push && cnt_q == LAST)) begin
                    state_d = IDLE;
                    rr_d    = grant_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign add_s_tdata = req_beat[grant_q];

    krnl_vadd_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TW)
    ) u_tag_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (push),
        .pop    (pop),
        .din    (grant_q),
        .full   (tag_full),
        .empty  (tag_empty),
        .head   (tag_head)
    );

    // Return routing depends only on the FIFO head, never on request side.
    always_comb begin
        rsp_tvalid   = '0;
        add_m_tready = 1'b0;
        if (!tag_empty) begin
            rsp_tvalid[tag_head] = add_m_tvalid;
            add_m_tready         = rsp_tready[tag_head];
        end
    end

    assign pop       = add_m_tvalid & add_m_tready;
    assign rsp_tdata = {NUM_REQ{add_m_tdata}};

    always_ff @(posedge aclk) begin
        if (areset) begin
            tag_err <= 1'b0;
        end else if (add_m_tvalid && tag_empty) begin
            tag_err <= 1'b1;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT) | ~tag_empty;

`ifdef KRNL_VADD_ARB_PERF_CNT_EN
    logic [31:0] beats_q [NUM_REQ];
    logic [31:0] stall_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
            stall_q <= '0;
        end else begin
            if (push) beats_q[grant_q] <= beats_q[grant_q] + 32'd1;
            if (state_q == GRANT && req_tvalid[grant_q] && tag_full) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    for (genvar gp = 0; gp < NUM_REQ; gp++) begin : g_perf
        assign perf_beats[gp*32 +: 32] = beats_q[gp];
    end
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_krnl_vadd_adder_arbiter.sv
// Self-checking bench: queue-based requesters, adder and scoreboard model.
// Builds with or without KRNL_VADD_ARB_PERF_CNT_EN.
module tb_krnl_vadd_adder_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BL  = 8;
    localparam int TD  = 16;
    localparam int TW  = 2;
    localparam int LAT = 3;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      req_tvalid;
    logic [N*2*DW-1:0] req_tdata;
    logic [N-1:0]      req_tready;
    logic [N-1:0]      rsp_tvalid;
    logic [N*(DW+1)-1:0] rsp_tdata;
    logic [N-1:0]      rsp_tready;
    logic              add_s_tvalid;
    logic [2*DW-1:0]   add_s_tdata;
    logic              add_s_tready;
    logic              add_m_tvalid;
    logic [DW:0]       add_m_tdata;
    logic              add_m_tready;
    logic [TW-1:0]     grant_id;
    logic              busy;
    logic              tag_err;
`ifdef KRNL_VADD_ARB_PERF_CNT_EN
    logic [N*32-1:0]   perf_beats;
    logic [31:0]       perf_stall;
`endif

    krnl_vadd_adder_arbiter #(
        .NUM_REQ      (N),
        .C_DATA_WIDTH (DW),
        .BURST_LEN    (BL),
        .TAG_DEPTH    (TD)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_tvalid   (req_tvalid),
        .req_tdata    (req_tdata),
        .req_tready   (req_tready),
        .rsp_tvalid   (rsp_tvalid),
        .rsp_tdata    (rsp_tdata),
        .rsp_tready   (rsp_tready),
        .add_s_tvalid (add_s_tvalid),
        .add_s_tdata  (add_s_tdata),
        .add_s_tready (add_s_tready),
        .add_m_tvalid (add_m_tvalid),
        .add_m_tdata  (add_m_tdata),
        .add_m_tready (add_m_tready),
        .grant_id     (grant_id),
        .busy         (busy),
        .tag_err      (tag_err)
`ifdef KRNL_VADD_ARB_PERF_CNT_EN
        ,
        .perf_beats   (perf_beats),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 aclk = ~aclk;

    int cmp_n = 0;
    int fail_n = 0;
    int cyc = 0;

    logic [2*DW-1:0] req_q [N][$];
    logic [DW:0]     exp_q [N][$];
    int              order_q[$];
    logic [DW:0]     addq_sum[$];
    int              addq_rdy[$];
    int              acc_id[$];
    int              acc_cyc[$];
    int              rsp_cnt [N];
    logic [N-1:0]    gap;
    logic [N-1:0]    hs_req;
    logic            hs_m;
    logic            err_hs;
    logic            err_m;
    int              t5_ids [7] = '{3, 3, 3, 0, 0, 2, 2};

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] beat_sum(input logic [2*DW-1:0] b);
        return {1'b0, b[2*DW-1:DW]} + {1'b0, b[DW-1:0]};
    endfunction

    function automatic int pending();
        int p;
        p = order_q.size();
        for (int i = 0; i < N; i++) p += req_q[i].size();
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_tvalid[i] = (req_q[i].size() > 0) && !gap[i];
            req_tdata[i*2*DW +: 2*DW] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
        end
        add_m_tvalid = (addq_sum.size() > 0) && (addq_rdy[0] <= cyc);
        add_m_tdata  = (addq_sum.size() > 0) ? addq_sum[0] : '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_tready"}, req_tready, 0);
        chk({tag, "_rsp_tvalid"}, rsp_tvalid, 0);
        chk({tag, "_add_s_tvalid"}, add_s_tvalid, 0);
        chk({tag, "_add_m_tready"}, add_m_tready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tag_err"}, tag_err, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    // Compare DUT against the queue model on every active cycle.
    always @(negedge aclk) begin : mon
        logic [N-1:0] ev;
        logic         em;
        int           h;
        if (!areset) begin
            ev = '0;
            em = 1'b0;
            h  = -1;
            if (order_q.size() > 0) begin
                h     = order_q[0];
                ev[h] = add_m_tvalid;
                em    = rsp_tready[h];
            end
            chk("rsp_tvalid", rsp_tvalid, ev);
            chk("add_m_tready", add_m_tready, em);
            chk("tag_err", tag_err, err_m);
            chk("req_tready_onehot", $onehot0(req_tready), 1);
            if (order_q.size() >= TD) chk("full_stall", req_tready, 0);
            hs_req = req_tvalid & req_tready;
            chk("s_handshake", add_s_tvalid & add_s_tready, |hs_req);
            for (int i = 0; i < N; i++) begin
                if (hs_req[i]) begin
                    chk("s_tdata", add_s_tdata, req_q[i][0]);
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            hs_m = add_m_tvalid & add_m_tready;
            if (hs_m && h >= 0) begin
                chk("rsp_tdata", rsp_tdata[h*(DW+1) +: DW+1], exp_q[h][0]);
            end
            err_hs = add_m_tvalid && (order_q.size() == 0);
        end
    end

    // Requester movers and adder pipeline react to the handshakes seen above.
    always @(posedge aclk) begin : drv
        logic        r;
        int          h;
        logic [DW:0] s;
        r = areset;
        #1;
        cyc++;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                req_q[i].delete();
                exp_q[i].delete();
            end
            order_q.delete();
            addq_sum.delete();
            addq_rdy.delete();
            err_m = 1'b0;
        end else begin
            if (err_hs) err_m = 1'b1;
            if (hs_m) begin
                if (addq_sum.size() > 0) begin
                    void'(addq_sum.pop_front());
                    void'(addq_rdy.pop_front());
                end
                if (order_q.size() > 0) begin
                    h = order_q.pop_front();
                    void'(exp_q[h].pop_front());
                    rsp_cnt[h]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (hs_req[i] && req_q[i].size() > 0) begin
                    s = beat_sum(req_q[i][0]);
                    order_q.push_back(i);
                    exp_q[i].push_back(s);
                    addq_sum.push_back(s);
                    addq_rdy.push_back(cyc + LAT);
                    void'(req_q[i].pop_front());
                end
            end
        end
        hs_req = '0;
        hs_m   = 1'b0;
        err_hs = 1'b0;
        drive();
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n0;
        int r0;
        areset       = 1'b1;
        rsp_tready   = '1;
        add_s_tready = 1'b1;
        gap          = '0;
        hs_req       = '0;
        hs_m         = 1'b0;
        err_hs       = 1'b0;
        err_m        = 1'b0;
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        drive();
        tick(3);
        areset = 1'b0;
        @(negedge aclk);
        chk_reset_outputs("rst");

        // Single beat a=5, b=7 from requester 1
        tick(1);
        req_q[1].push_back({32'd7, 32'd5});
        drive();
        t = 0;
        @(negedge aclk);
        while (!(req_tvalid[1] && req_tready[1]) && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t1_hs_timeout", t < 50, 1);
        chk("t1_s_tdata", add_s_tdata, 64'h0000_0007_0000_0005);
        chk("t1_grant_id", grant_id, 1);
        t = 0;
        while (!rsp_tvalid[1] && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t1_rsp_timeout", t < 50, 1);
        chk("t1_rsp_sum", rsp_tdata[1*(DW+1) +: DW+1], 33'd12);
        t = 0;
        while (busy && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t1_busy_drop", busy, 0);

        // Four continuously valid requesters
        tick(1);
        pulse_reset();
        n0 = acc_id.size();
        for (int i = 0; i < N; i++) begin
            rsp_cnt[i] = 0;
            for (int k = 0; k < 16; k++) begin
                req_q[i].push_back({32'(k * 3 + 1), 32'(i * 1000 + k)});
            end
        end
        drive();
        t = 0;
        while (pending() != 0 && t < 600) begin
            tick(1);
            t++;
        end
        chk("t2_drain_timeout", t < 600, 1);
        chk("t2_accepted", acc_id.size() - n0, 64);
        for (int k = 0; k < 40; k++) begin
            chk("t2_grant_order", acc_id[n0 + k], (k / BL) % N);
            if (k > 0) begin
                chk("t2_beat_spacing", acc_cyc[n0 + k] - acc_cyc[n0 + k - 1],
                    (k % BL == 0) ? 2 : 1);
            end
        end
        for (int i = 0; i < N; i++) chk("t2_rsp_count", rsp_cnt[i], 16);

        // Carry out of the sum on requester 2
        req_q[2].push_back({32'h0000_0001, 32'hFFFF_FFFF});
        drive();
        t = 0;
        @(negedge aclk);
        while (!rsp_tvalid[2] && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t3_rsp_timeout", t < 50, 1);
        chk("t3_rsp_sum", rsp_tdata[2*(DW+1) +: DW+1], 33'h1_0000_0000);

        // Tag FIFO fills while requester 0 cannot take responses
        tick(2);
        rsp_tready[0] = 1'b0;
        n0 = acc_id.size();
        r0 = rsp_cnt[0];
        for (int k = 0; k < 20; k++) begin
            req_q[0].push_back({32'(k + 100), 32'(k * 7)});
        end
        drive();
        tick(60);
        chk("t4_accepted_at_full", acc_id.size() - n0, 16);
        @(negedge aclk);
        chk("t4_req_tready_low", req_tready, 0);
        chk("t4_req_still_valid", req_tvalid[0], 1);
        chk("t4_busy", busy, 1);
        tick(1);
        rsp_tready[0] = 1'b1;
        t = 0;
        while (rsp_cnt[0] - r0 < 20 && t < 300) begin
            tick(1);
            t++;
        end
        chk("t4_drained", rsp_cnt[0] - r0, 20);

        // Requester 3 gaps after 3 beats; others wait behind it
        tick(2);
        pulse_reset();
        n0 = acc_id.size();
        for (int k = 0; k < 3; k++) req_q[3].push_back({32'd1, 32'(k)});
        drive();
        t = 0;
        while (acc_id.size() == n0 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t5_first_timeout", t < 50, 1);
        for (int k = 0; k < 2; k++) begin
            req_q[0].push_back({32'd2, 32'(k)});
            req_q[2].push_back({32'd3, 32'(k)});
        end
        drive();
        t = 0;
        while (acc_id.size() < n0 + 7 && t < 100) begin
            tick(1);
            t++;
        end
        chk("t5_accept_timeout", t < 100, 1);
        for (int k = 0; k < 7; k++) chk("t5_grant_order", acc_id[n0 + k], t5_ids[k]);
        chk("t5_gap_3_to_0", acc_cyc[n0 + 3] - acc_cyc[n0 + 2], 3);
        chk("t5_gap_0_to_2", acc_cyc[n0 + 5] - acc_cyc[n0 + 4], 3);
        @(negedge aclk);
        chk("t5_grant_id", grant_id, 2);

        // Reset mid-burst with beats in flight
        tick(10);
        rsp_tready[1] = 1'b0;
        n0 = acc_id.size();
        for (int k = 0; k < 8; k++) req_q[1].push_back({32'd9, 32'(k)});
        drive();
        t = 0;
        while (acc_id.size() < n0 + 5 && t < 50) begin
            tick(1);
            t++;
        end
        chk("t6_inflight_timeout", t < 50, 1);
        pulse_reset();
        @(negedge aclk);
        chk_reset_outputs("t6");
        tick(1);
        rsp_tready = '1;
        r0 = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
        tick(20);
        chk("t6_no_stale", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3], r0);

        // Adder result with no tag outstanding
        addq_sum.push_back(33'h5);
        addq_rdy.push_back(0);
        drive();
        tick(3);
        @(negedge aclk);
        chk("t7_tag_err_set", tag_err, 1);
        chk("t7_m_tready_held", add_m_tready, 0);
        tick(1);
        pulse_reset();
        @(negedge aclk);
        chk("t7_tag_err_clear", tag_err, 0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule

// File: doc/krnl_vadd_adder_arbiter.md
Name: krnl_vadd_adder_arbiter

Overview:
Shares one krnl_vadd_rtl_adder instance among NUM_REQ AXI-Stream requesters.
- Round-robin, burst-locked arbitration of operand beats ({b,a}, 2×C_DATA_WIDTH) into the adder slave port.
- Records the requester ID of every accepted beat in an in-order tag FIFO.
- Routes each (C_DATA_WIDTH+1)-bit sum from the adder master port back to the originating requester's response stream.
- Sits between the kernel's per-channel read movers and the adder, inside the vadd kernel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
C_DATA_WIDTH, 32, operand width; request beat 2*C_DATA_WIDTH, response beat C_DATA_WIDTH+1
BURST_LEN, 8, max beats granted per arbitration win (1..255)
TAG_DEPTH, 16, tag FIFO entries (power of 2); bounds adder in-flight beats

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
req_tvalid  in  NUM_REQ  per-requester operand valid
req_tdata  in  NUM_REQ*2*C_DATA_WIDTH  requester i occupies slice i
req_tready  out  NUM_REQ  per-requester ready
rsp_tvalid  out  NUM_REQ  per-requester sum valid
rsp_tdata  out  NUM_REQ*(C_DATA_WIDTH+1)  adder sum broadcast to all slices
rsp_tready  in  NUM_REQ  per-requester sum ready
add_s_tvalid  out  1  to adder s_tvalid
add_s_tdata  out  2*C_DATA_WIDTH  to adder s_tdata
add_s_tready  in  1  from adder s_tready
add_m_tvalid  in  1  from adder m_tvalid
add_m_tdata  in  C_DATA_WIDTH+1  from adder m_tdata
add_m_tready  out  1  to adder m_tready
grant_id  out  clog2(NUM_REQ)  current/last granted requester
busy  out  1  high in GRANT or while tag FIFO is non-empty
tag_err  out  1  sticky: adder produced a result with the tag FIFO empty

Behaviour:
- Clock aclk; reset areset is synchronous, active-high. Reset clears: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, tag FIFO empty, tag_err=0. All tvalid/tready outputs evaluate to 0 in reset state; busy=0.
- areset also resets the adder. Beats in flight when reset asserts are discarded and no response is issued.
- FSM IDLE:
  - grant_id <= first i at or after rr_ptr (wrapping) with req_tvalid[i]=1; beat_cnt <= 0; go to GRANT.
  - No valid request: stay in IDLE.
  - Result: one bubble cycle per arbitration.
- FSM GRANT (g = grant_id):
  - add_s_tvalid = req_tvalid[g] & !tag_full.
  - req_tready[g] = add_s_tready & !tag_full; all other req_tready = 0.
  - add_s_tdata = slice g of req_tdata.
  - On each handshake: push g into tag FIFO; beat_cnt++.
- GRANT exit to IDLE, with rr_ptr <= (g+1) mod NUM_REQ:
  - handshake occurs with beat_cnt == BURST_LEN-1, or
  - req_tvalid[g]=0 in any GRANT cycle (requester gap releases the grant).
- Backpressure: tag_full stalls the request path without leaving GRANT and without counting beats.
- Return path, with h = tag FIFO head:
  - rsp_tvalid[h] = add_m_tvalid & !tag_empty; other rsp_tvalid = 0.
  - add_m_tready = rsp_tready[h] & !tag_empty.
  - Pop on add_m handshake.
  - Response order per requester equals request order (the adder is in-order).
- add_m_tvalid with tag_empty: add_m_tready held 0; tag_err set (sticky until reset).
- Same-cycle push and pop: allowed; occupancy unchanged. Full is evaluated on the pre-pop count, so push is blocked when full even if a pop occurs in that cycle.
- No combinational path from rsp_tready to req_tready.

Optional Feature:
Macro KRNL_VADD_ARB_PERF_CNT_EN.
- Defined: per-requester 32-bit wrapping counters of accepted request beats, plus a 32-bit counter of cycles where tag_full stalls a valid request. Exposed on output perf_beats (NUM_REQ*32) and output perf_stall (32). Cleared by areset.
- Undefined: counters and ports are absent; all other behaviour is identical.

Decomposition:
- Package krnl_vadd_arb_pkg holds:
  - FSM state enum {IDLE, GRANT}
  - tag width function clog2(NUM_REQ)
  - FIFO pointer width derived from TAG_DEPTH
- Sub-module krnl_vadd_tag_fifo: synchronous FIFO with push, pop, full, empty and head outputs, extra MSB on pointers for full detection.
- Arbiter, burst counter and routing stay in the top module.

Test Plan:
- Single requester 1 sends a=5, b=7 → one add_s beat {7,5}; rsp_tvalid[1] carries 12; grant_id=1; busy drops after the pop.
- All 4 requesters continuously valid, BURST_LEN=8 → grant order 0,1,2,3,0; exactly 8 beats each; 1 idle cycle between bursts; each rsp stream receives only its own sums, in order.
- a=0xFFFFFFFF, b=1 on requester 2 → rsp slice 2 = 33'h1_0000_0000.
- rsp_tready[0] held 0 with TAG_DEPTH=16 → after 16 accepted beats req_tready drops. Releasing rsp_tready drains all 16 in order with no beat lost.
- Requester 3 drops tvalid after 3 beats → grant released; rr_ptr=0; next waiting requester is granted after one bubble.
- areset pulsed for 1 cycle mid-burst with 5 beats in flight → next cycle: all outputs at reset values, FIFO empty, tag_err=0, and no stale responses afterwards.
